// File: rtl/video_pkg.sv
// Shared types and defaults for the video path: issue FSM states and the
// packed {dataB, dataA} instruction entry width.
package video_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } iq_state_t;

  localparam int INSTR_W   = 64;
  localparam int IQ_DEPTH  = 16;
  localparam int IQ_ADDR_W = 4;
  localparam int IQ_GAP    = 8;

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage for the instruction queue: synchronous write and
// a registered read that only loads on request, so its output holds the last
// issued entry between issues.
module sync_fifo_mem
  import video_pkg::*;
#(
  parameter int DEPTH  = IQ_DEPTH,
  parameter int ADDR_W = IQ_ADDR_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               wr_en_i,
  input  logic [ADDR_W-1:0]  wr_addr_i,
  input  logic [INSTR_W-1:0] wr_data_i,
  input  logic               rd_en_i,
  input  logic [ADDR_W-1:0]  rd_addr_i,
  output logic [INSTR_W-1:0] rd_data_o
);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [INSTR_W-1:0] rd_data_q;

  // Entry storage; the array itself carries no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read register: loads the addressed entry only when an issue is taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= {INSTR_W{1'b0}};
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/instruction_queue.sv
// Instruction queue between the Nios II custom-instruction port and
// video_processor. Pushes are acknowledged with cpu_done; a push into a full
// queue parks in a single pending slot until space frees up. Entries are
// replayed one at a time, only while the screen is not being printed, with
// vp_start pulses at least GAP cycles apart.
module instruction_queue
  import video_pkg::*;
#(
  parameter int DEPTH  = IQ_DEPTH,
  parameter int ADDR_W = IQ_ADDR_W,
  parameter int GAP    = IQ_GAP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_clk_en,
  input  logic        cpu_start,
  input  logic [31:0] cpu_dataA,
  input  logic [31:0] cpu_dataB,
  output logic        cpu_done,
  output logic [31:0] cpu_result,
  input  logic        printtingScreen,
  output logic        vp_start,
  output logic        vp_clk_en,
  output logic [31:0] vp_dataA,
  output logic [31:0] vp_dataB,
  output logic        full,
  output logic        empty
);

  localparam int CNT_W = $clog2(GAP) + 1;
  localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W + 1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_INC   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_INC   = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP - 2);
  localparam logic [CNT_W-1:0]  GAP_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  GAP_ZERO  = {CNT_W{1'b0}};

  // Queue bookkeeping
  logic [ADDR_W-1:0]  head_q;
  logic [ADDR_W-1:0]  tail_q;
  logic [ADDR_W:0]    count_q;
  logic [ADDR_W:0]    count_d;
  logic               pend_q;
  logic [INSTR_W-1:0] pend_data_q;

  // Issue sequencer
  iq_state_t          state_q;
  logic [CNT_W-1:0]   gap_cnt_q;

  // Registered outputs
  logic               cpu_done_q;
  logic [31:0]        cpu_result_q;
  logic               vp_start_q;
  logic               full_q;
  logic               empty_q;

  logic               req_s;
  logic               q_full_s;
  logic               push_s;
  logic               pop_s;
  logic               issue_go_s;
  logic [INSTR_W-1:0] wr_data_s;
  logic [INSTR_W-1:0] rd_data_s;

  assign req_s      = cpu_clk_en & cpu_start;
  assign q_full_s   = (count_q == FULL_CNT);
  assign pop_s      = (state_q == ISSUE);
  assign issue_go_s = (state_q == IDLE) && (count_q != CNT_ZERO) && !printtingScreen;

  // Write source: a parked request has priority and blocks new starts.
  always_comb begin
    push_s    = 1'b0;
    wr_data_s = {cpu_dataB, cpu_dataA};
    if (pend_q) begin
      push_s    = !q_full_s;
      wr_data_s = pend_data_q;
    end else begin
      push_s    = req_s & !q_full_s;
      wr_data_s = {cpu_dataB, cpu_dataA};
    end
  end

  // Occupancy after this edge; simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    if (push_s && !pop_s) begin
      count_d = count_q + CNT_INC;
    end else if (!push_s && pop_s) begin
      count_d = count_q - CNT_INC;
    end else begin
      count_d = count_q;
    end
  end

  // Pointers, count, status flags, pending slot and the CPU handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q       <= {ADDR_W{1'b0}};
      tail_q       <= {ADDR_W{1'b0}};
      count_q      <= CNT_ZERO;
      pend_q       <= 1'b0;
      pend_data_q  <= {INSTR_W{1'b0}};
      cpu_done_q   <= 1'b0;
      cpu_result_q <= 32'd0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
    end else begin
      count_q    <= count_d;
      full_q     <= (count_d == FULL_CNT);
      empty_q    <= (count_d == CNT_ZERO);
      cpu_done_q <= push_s;
      if (push_s) begin
        tail_q       <= tail_q + PTR_INC;
        cpu_result_q <= 32'(count_d);
      end
      if (pop_s) begin
        head_q <= head_q + PTR_INC;
      end
      if (pend_q) begin
        if (push_s) begin
          pend_q <= 1'b0;
        end
      end else if (req_s && q_full_s) begin
        pend_q      <= 1'b1;
        pend_data_q <= {cpu_dataB, cpu_dataA};
      end
    end
  end

  // Issue FSM. gap_cnt_q holds the number of WAIT cycles still to spend,
  // counting the current one, so ISSUE + WAIT + IDLE spans exactly GAP cycles
  // between consecutive vp_start pulses. With GAP = 2 there is no WAIT cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      gap_cnt_q  <= GAP_ZERO;
      vp_start_q <= 1'b0;
    end else begin
      vp_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (issue_go_s) begin
            state_q    <= ISSUE;
            vp_start_q <= 1'b1;
          end
        end
        ISSUE: begin
          gap_cnt_q <= GAP_LOAD;
          state_q   <= (GAP_LOAD == GAP_ZERO) ? IDLE : WAIT;
        end
        WAIT: begin
          if (gap_cnt_q <= GAP_ONE) begin
            state_q <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  sync_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i     (clk),
    .rst_ni    (reset),
    .wr_en_i   (push_s),
    .wr_addr_i (tail_q),
    .wr_data_i (wr_data_s),
    .rd_en_i   (issue_go_s),
    .rd_addr_i (head_q),
    .rd_data_o (rd_data_s)
  );

  assign cpu_done   = cpu_done_q;
  assign cpu_result = cpu_result_q;
  assign vp_start   = vp_start_q;
  assign vp_clk_en  = vp_start_q;
  assign vp_dataA   = rd_data_s[31:0];
  assign vp_dataB   = rd_data_s[63:32];
  assign full       = full_q;
  assign empty      = empty_q;

endmodule

// File: tb/tb_instruction_queue.sv
// Bench for instruction_queue: a queue-level reference model checked every
// cycle, directed scenarios with literal expectations, and a randomized
// push/busy phase with an issue-order scoreboard.
module tb_instruction_queue;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int GAP    = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_clk_en = 1'b0;
  logic        cpu_start = 1'b0;
  logic [31:0] cpu_dataA = 32'd0;
  logic [31:0] cpu_dataB = 32'd0;
  logic        printtingScreen = 1'b0;
  logic        cpu_done;
  logic [31:0] cpu_result;
  logic        vp_start;
  logic        vp_clk_en;
  logic [31:0] vp_dataA;
  logic [31:0] vp_dataB;
  logic        full;
  logic        empty;

  instruction_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .cpu_clk_en(cpu_clk_en), .cpu_start(cpu_start),
    .cpu_dataA(cpu_dataA), .cpu_dataB(cpu_dataB), .cpu_done(cpu_done),
    .cpu_result(cpu_result), .printtingScreen(printtingScreen),
    .vp_start(vp_start), .vp_clk_en(vp_clk_en), .vp_dataA(vp_dataA),
    .vp_dataB(vp_dataB), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (queue level) ----------------
  logic [63:0] mq[$];
  bit          m_pend = 1'b0;
  logic [63:0] m_pend_data = 64'd0;
  int          m_since = 1000;   // edges since the last issue edge
  int          m_cnt_b;
  bit          m_issue, m_pop, m_push;
  logic [63:0] m_pdata;
  logic        e_done = 1'b0;
  logic [31:0] e_result = 32'd0;
  logic        e_vs = 1'b0;
  logic [31:0] e_a = 32'd0;
  logic [31:0] e_b = 32'd0;
  logic        e_full = 1'b0;
  logic        e_empty = 1'b1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_pend = 1'b0; m_pend_data = 64'd0; m_since = 1000;
      e_done = 1'b0; e_result = 32'd0; e_vs = 1'b0; e_a = 32'd0; e_b = 32'd0;
      e_full = 1'b0; e_empty = 1'b1;
    end else begin
      m_cnt_b = mq.size();
      if (m_since < 1000) m_since++;
      m_issue = (m_since >= GAP) && (m_cnt_b > 0) && !printtingScreen;
      m_pop   = e_vs;
      m_push  = 1'b0;
      m_pdata = {cpu_dataB, cpu_dataA};
      if (m_pend) begin
        if (m_cnt_b < DEPTH) begin
          m_push = 1'b1; m_pdata = m_pend_data; m_pend = 1'b0;
        end
      end else if (cpu_clk_en && cpu_start) begin
        if (m_cnt_b < DEPTH) m_push = 1'b1;
        else begin m_pend = 1'b1; m_pend_data = {cpu_dataB, cpu_dataA}; end
      end
      if (m_issue) begin
        e_a = mq[0][31:0]; e_b = mq[0][63:32]; m_since = 0;
      end
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(m_pdata);
      e_vs    = m_issue;
      e_done  = m_push;
      if (m_push) e_result = mq.size();
      e_full  = (mq.size() == DEPTH);
      e_empty = (mq.size() == 0);
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("cpu_done",   64'(cpu_done),   64'(e_done));
    chk("cpu_result", 64'(cpu_result), 64'(e_result));
    chk("vp_start",   64'(vp_start),   64'(e_vs));
    chk("vp_clk_en",  64'(vp_clk_en),  64'(e_vs));
    chk("vp_dataA",   64'(vp_dataA),   64'(e_a));
    chk("vp_dataB",   64'(vp_dataB),   64'(e_b));
    chk("full",       64'(full),       64'(e_full));
    chk("empty",      64'(empty),      64'(e_empty));
  end

  // ---------------- issue-order scoreboard ----------------
  logic [63:0] pushed[$];
  logic [63:0] issued[$];
  bit          sb_on = 1'b0;

  always @(negedge clk) begin
    if (sb_on && reset && vp_start) issued.push_back({vp_dataB, vp_dataA});
  end

  task automatic sb_compare(input string name);
    chk({name, "_count"}, 64'(issued.size()), 64'(pushed.size()));
    for (int i = 0; i < pushed.size() && i < issued.size(); i++)
      chk({name, "_order"}, issued[i], pushed[i]);
  endtask

  // ---------------- drivers (called right after a negedge) ----------------
  task automatic drive_req(input logic [31:0] a, input logic [31:0] b);
    cpu_clk_en = 1'b1; cpu_start = 1'b1; cpu_dataA = a; cpu_dataB = b;
    @(negedge clk);
    cpu_clk_en = 1'b0; cpu_start = 1'b0;
  endtask

  task automatic wait_vs(input string name, input int limit);
    int n = 0;
    while (!vp_start && n < limit) begin @(negedge clk); n++; end
    if (!vp_start) chk({name, "_vs_timeout"}, 64'(vp_start), 64'd1);
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while (!empty && n < limit) begin @(negedge clk); n++; end
    if (!empty) chk({name, "_drain_timeout"}, 64'(empty), 64'd1);
    repeat (GAP + 2) @(negedge clk);
  endtask

  initial begin
    int n, k;
    int t[3];
    logic [31:0] d[3];
    logic [31:0] a, b;
    bit seen;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_done", 64'(cpu_done), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // 1: single push, issue two cycles after the push
    drive_req(32'h3fff1, 32'd12);
    chk("t1_done", 64'(cpu_done), 64'd1);
    chk("t1_result", 64'(cpu_result), 64'd1);
    @(negedge clk);
    chk("t1_vs", 64'(vp_start), 64'd1);
    chk("t1_a", 64'(vp_dataA), 64'h3fff1);
    chk("t1_b", 64'(vp_dataB), 64'd12);
    repeat (3) @(negedge clk);
    chk("t1_empty", 64'(empty), 64'd1);
    repeat (GAP) @(negedge clk);

    // 2: blocked by printtingScreen, then GAP-spaced issues in order
    printtingScreen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_req(32'd100 + 32'(i), 32'd200 + 32'(i));
      chk("t2_result", 64'(cpu_result), 64'(i + 1));
    end
    seen = 1'b0;
    repeat (10) begin if (vp_start) seen = 1'b1; @(negedge clk); end
    chk("t2_blocked", 64'(seen), 64'd0);
    printtingScreen = 1'b0;
    k = 0; n = 0;
    while (k < 3 && n < 100) begin
      if (vp_start) begin t[k] = cyc; d[k] = vp_dataA; k++; end
      @(negedge clk); n++;
    end
    chk("t2_pulses", 64'(k), 64'd3);
    if (k == 3) begin
      chk("t2_gap01", 64'(t[1] - t[0]), 64'(GAP));
      chk("t2_gap12", 64'(t[2] - t[1]), 64'(GAP));
      for (int i = 0; i < 3; i++) chk("t2_order", 64'(d[i]), 64'(100 + i));
    end
    wait_drain("t2", 100);

    // 3: fill to full, 17th push parks until the first pop
    printtingScreen = 1'b1;
    pushed.delete(); issued.delete(); sb_on = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      drive_req(32'd300 + 32'(i), 32'(i));
      pushed.push_back({32'(i), 32'd300 + 32'(i)});
    end
    chk("t3_full", 64'(full), 64'd1);
    drive_req(32'd316, 32'd16);
    pushed.push_back({32'd16, 32'd316});
    seen = 1'b0;
    repeat (5) begin if (cpu_done) seen = 1'b1; @(negedge clk); end
    chk("t3_withheld", 64'(seen), 64'd0);
    printtingScreen = 1'b0;
    wait_vs("t3", 20);
    repeat (2) @(negedge clk);
    chk("t3_late_done", 64'(cpu_done), 64'd1);
    chk("t3_late_result", 64'(cpu_result), 64'd16);
    wait_drain("t3", 400);
    sb_on = 1'b0;
    sb_compare("t3");

    // 4: push during the ISSUE cycle with 5 queued
    printtingScreen = 1'b1;
    for (int i = 0; i < 5; i++) drive_req(32'd400 + 32'(i), 32'd4);
    printtingScreen = 1'b0;
    wait_vs("t4", 20);
    drive_req(32'h500, 32'h55);
    chk("t4_done", 64'(cpu_done), 64'd1);
    chk("t4_result", 64'(cpu_result), 64'd5);
    wait_drain("t4", 200);

    // 5: asynchronous reset in the middle of WAIT
    printtingScreen = 1'b1;
    for (int i = 0; i < 4; i++) drive_req(32'd600 + 32'(i), 32'd6);
    printtingScreen = 1'b0;
    wait_vs("t5", 20);
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("t5_done", 64'(cpu_done), 64'd0);
    chk("t5_result", 64'(cpu_result), 64'd0);
    chk("t5_vs", 64'(vp_start), 64'd0);
    chk("t5_clken", 64'(vp_clk_en), 64'd0);
    chk("t5_a", 64'(vp_dataA), 64'd0);
    chk("t5_b", 64'(vp_dataB), 64'd0);
    chk("t5_full", 64'(full), 64'd0);
    chk("t5_empty", 64'(empty), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (30) begin if (vp_start) seen = 1'b1; @(negedge clk); end
    chk("t5_quiet", 64'(seen), 64'd0);

    // 6: randomized pushes and busy flag, with wrap-around and full stalls
    pushed.delete(); issued.delete(); sb_on = 1'b1;
    for (int i = 0; i < 24; i++) begin
      a = $urandom; b = $urandom;
      pushed.push_back({b, a});
      printtingScreen = ($urandom_range(0, 3) == 0);
      drive_req(a, b);
      n = 0;
      while (!cpu_done && n < 400) begin
        printtingScreen = ($urandom_range(0, 3) == 0);
        @(negedge clk); n++;
      end
      if (!cpu_done) chk("t6_push_timeout", 64'(cpu_done), 64'd1);
      repeat ($urandom_range(0, 6)) begin
        printtingScreen = ($urandom_range(0, 3) == 0);
        @(negedge clk);
      end
    end
    printtingScreen = 1'b0;
    wait_drain("t6", 600);
    sb_on = 1'b0;
    sb_compare("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
